// File: rtl/sample_reader.sv
// Reads samples from a RAM ring written by an upstream writer and presents them on a registered valid/ready port.
// Optional decimation is enabled with the SAMPLE_READER_DECIM_EN define.
module sample_reader #(
   parameter int DATA_WIDTH = 12,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH:0]   w_ptr_i,
   output logic [ADDR_WIDTH-1:0] r_addr_o,
   input  logic [DATA_WIDTH-1:0] r_data_i,
   output logic [ADDR_WIDTH:0]   r_ptr_o,
   input  logic                  flush_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  empty_o,
   output logic [ADDR_WIDTH:0]   level_o,
`ifdef SAMPLE_READER_DECIM_EN
   input  logic [7:0]            decim_i,
`endif
   output logic                  state_o
);

   // Handshake: a sample transfers on any rising edge where valid_o and ready_i are both high;
   // once valid_o is raised, data_o stays fixed until that transfer (or a flush/reset) happens.

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t state_q;
   logic   fetch;

   assign empty_o  = (w_ptr_i == r_ptr_o);
   assign level_o  = w_ptr_i - r_ptr_o;
   assign r_addr_o = r_ptr_o[ADDR_WIDTH-1:0];
   assign state_o  = (state_q == ST_HOLD);

`ifdef SAMPLE_READER_DECIM_EN
   logic [7:0] phase_q;
   logic [7:0] phase_next;

   assign phase_next = (phase_q >= decim_i) ? 8'd0 : phase_q + 8'd1;
   // Skipped words are only consumed while nothing is held, so a held sample is never overwritten.
   assign fetch = !empty_o && ((state_q == ST_EMPTY) || (ready_i && (phase_q == 8'd0)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr_o <= '0;
         data_o  <= '0;
         valid_o <= 1'b0;
         state_q <= ST_EMPTY;
         phase_q <= 8'd0;
      end else if (flush_i) begin
         r_ptr_o <= w_ptr_i;
         valid_o <= 1'b0;
         state_q <= ST_EMPTY;
         phase_q <= 8'd0;
      end else if (fetch) begin
         r_ptr_o <= r_ptr_o + PTR_ONE;
         phase_q <= phase_next;
         if (phase_q == 8'd0) begin
            data_o  <= r_data_i;
            valid_o <= 1'b1;
            state_q <= ST_HOLD;
         end else begin
            valid_o <= 1'b0;
            state_q <= ST_EMPTY;
         end
      end else if ((state_q == ST_HOLD) && ready_i) begin
         valid_o <= 1'b0;
         state_q <= ST_EMPTY;
      end
   end
`else
   assign fetch = !empty_o && ((state_q == ST_EMPTY) || ready_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ptr_o <= '0;
         data_o  <= '0;
         valid_o <= 1'b0;
         state_q <= ST_EMPTY;
      end else if (flush_i) begin
         r_ptr_o <= w_ptr_i;
         valid_o <= 1'b0;
         state_q <= ST_EMPTY;
      end else if (fetch) begin
         r_ptr_o <= r_ptr_o + PTR_ONE;
         data_o  <= r_data_i;
         valid_o <= 1'b1;
         state_q <= ST_HOLD;
      end else if ((state_q == ST_HOLD) && ready_i) begin
         valid_o <= 1'b0;
         state_q <= ST_EMPTY;
      end
   end
`endif

endmodule

// File: tb/tb_sample_reader.sv
// Bench for sample_reader: RAM and writer model, directed cases plus randomized traffic against a queue model.
// Builds with or without SAMPLE_READER_DECIM_EN.
module tb_sample_reader;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [8:0]  w_ptr = '0;
   logic [7:0]  r_addr;
   logic [11:0] r_data;
   logic [8:0]  r_ptr;
   logic        flush_i = 1'b0;
   logic [11:0] data_o;
   logic        valid_o;
   logic        ready_i = 1'b0;
   logic        empty_o;
   logic [8:0]  level_o;
   logic        state_o;
`ifdef SAMPLE_READER_DECIM_EN
   logic [7:0]  decim_i = 8'd0;
`endif

   logic [11:0] ram [256];
   logic [11:0] exp_q [$];
   logic        exp_valid = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   assign r_data = ram[r_addr];

   always #5 clk = ~clk;

   sample_reader #(.DATA_WIDTH(12), .ADDR_WIDTH(8)) dut (
      .clk_i    (clk),
      .rst_i    (rst_i),
      .w_ptr_i  (w_ptr),
      .r_addr_o (r_addr),
      .r_data_i (r_data),
      .r_ptr_o  (r_ptr),
      .flush_i  (flush_i),
      .data_o   (data_o),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .empty_o  (empty_o),
      .level_o  (level_o),
`ifdef SAMPLE_READER_DECIM_EN
      .decim_i  (decim_i),
`endif
      .state_o  (state_o)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Model: exp_q holds every written, not yet accepted word; its head is what data_o must show.
   task automatic check_model();
      logic [8:0] e_level;
      logic [8:0] e_ptr;
      exp_valid = (exp_q.size() > 0);
      e_level   = (exp_q.size() > 0) ? 9'(exp_q.size() - 1) : 9'd0;
      e_ptr     = w_ptr - e_level;
      check("valid", 32'(valid_o), 32'(exp_valid));
      if (exp_valid) check("data", 32'(data_o), 32'(exp_q[0]));
      check("level", 32'(level_o), 32'(e_level));
      check("empty", 32'(empty_o), 32'(e_level == 9'd0));
      check("r_ptr", 32'(r_ptr), 32'(e_ptr));
      check("r_addr", 32'(r_addr), 32'(e_ptr[7:0]));
   endtask

   task automatic put_word(input logic [11:0] val);
      ram[w_ptr[7:0]] = val;
      exp_q.push_back(val);
      w_ptr = w_ptr + 9'd1;
   endtask

   // Called at a negedge: drive one cycle of stimulus, clock it, then check the model.
   task automatic cycle(input int n_wr, input logic rdy, input logic fl);
      ready_i = rdy;
      flush_i = fl;
      if (exp_valid && rdy && !fl) void'(exp_q.pop_front());
      for (int i = 0; i < n_wr; i++)
         if (exp_q.size() < 256) put_word(12'($urandom_range(0, 4095)));
      if (fl) exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      flush_i = 1'b0;
      check_model();
   endtask

   task automatic do_reset(input logic fl);
      rst_i   = 1'b1;
      flush_i = fl;
      ready_i = 1'($urandom_range(0, 1));
      w_ptr   = '0;
      exp_q.delete();
      @(posedge clk);
      @(negedge clk);
      rst_i   = 1'b0;
      flush_i = 1'b0;
      exp_valid = 1'b0;
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_data", 32'(data_o), 32'd0);
      check("rst_r_ptr", 32'(r_ptr), 32'd0);
      check("rst_empty", 32'(empty_o), 32'd1);
      check("rst_level", 32'(level_o), 32'd0);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() > 0; i++) cycle(0, 1'b1, 1'b0);
      check("drain_left", 32'(exp_q.size()), 32'd0);
      check("drain_empty", 32'(empty_o), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = '0;
      @(negedge clk);
      do_reset(1'b0);

      // Three words streamed back-to-back.
      put_word(12'h001); put_word(12'h002); put_word(12'h003);
      cycle(0, 1'b1, 1'b0); check("seq0", 32'(data_o), 32'h001);
      cycle(0, 1'b1, 1'b0); check("seq1", 32'(data_o), 32'h002);
      cycle(0, 1'b1, 1'b0); check("seq2", 32'(data_o), 32'h003);
      check("seq_empty", 32'(empty_o), 32'd1);
      check("seq_level", 32'(level_o), 32'd0);
      cycle(0, 1'b1, 1'b0); check("seq_idle", 32'(valid_o), 32'd0);

      // Stalled consumer with five words, then released.
      do_reset(1'b0);
      cycle(5, 1'b0, 1'b0);
      check("stall_data", 32'(data_o), 32'(ram[0]));
      check("stall_ptr", 32'(r_ptr), 32'd1);
      check("stall_level", 32'(level_o), 32'd4);
      cycle(0, 1'b0, 1'b0);
      check("stall_hold", 32'(data_o), 32'(ram[0]));
      for (int i = 1; i <= 4; i++) begin
         cycle(0, 1'b1, 1'b0);
         check("stall_burst", 32'(data_o), 32'(ram[i]));
      end
      cycle(0, 1'b1, 1'b0);

      // Pointer wrap from 0x0FF to 0x101.
      do_reset(1'b0);
      for (int i = 0; i < 255; i++) put_word(12'($urandom_range(0, 4095)));
      drain();
      check("wrap_start_ptr", 32'(r_ptr), 32'h0FF);
      check("wrap_start_addr", 32'(r_addr), 32'hFF);
      put_word(12'hA5A); put_word(12'h5A5);
      cycle(0, 1'b1, 1'b0);
      check("wrap_data0", 32'(data_o), 32'hA5A);
      check("wrap_addr0", 32'(r_addr), 32'h00);
      cycle(0, 1'b1, 1'b0);
      check("wrap_data1", 32'(data_o), 32'h5A5);
      check("wrap_end_ptr", 32'(r_ptr), 32'h101);

      // Flush while holding with a simultaneous handshake.
      do_reset(1'b0);
      for (int i = 0; i < 64; i++) put_word(12'($urandom_range(0, 4095)));
      cycle(0, 1'b0, 1'b0);
      cycle(0, 1'b1, 1'b1);
      check("flush_valid", 32'(valid_o), 32'd0);
      check("flush_ptr", 32'(r_ptr), 32'h040);
      check("flush_empty", 32'(empty_o), 32'd1);

      // Reset overriding a flush while a sample is held.
      put_word(12'h777); put_word(12'h123);
      cycle(0, 1'b0, 1'b0);
      check("pre_rst_valid", 32'(valid_o), 32'd1);
      do_reset(1'b1);

`ifdef SAMPLE_READER_DECIM_EN
      begin
         logic [11:0] got_q [$];
         decim_i = 8'd2;
         do_reset(1'b0);
         for (int i = 0; i < 9; i++) put_word(12'(i));
         ready_i = 1'b1;
         for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_o) got_q.push_back(data_o);
         end
         check("decim_count", 32'(got_q.size()), 32'd3);
         for (int i = 0; i < 3 && i < got_q.size(); i++)
            check("decim_data", 32'(got_q[i]), 32'(3 * i));
         check("decim_empty", 32'(empty_o), 32'd1);
         decim_i = 8'd0;
      end
`endif

      // Randomized traffic with occasional flushes.
      do_reset(1'b0);
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 2), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
      drain();
      check("final_ptr", 32'(r_ptr), 32'(w_ptr));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
